// File: rtl/fabric_ccff_loader.sv
// -----------------------------------------------------------------------------
// fabric_ccff_loader
//
// Purpose:
//   Loads the configuration chain (ccff_head -> ccff_tail) of a run of fabric
//   tiles. Configuration words arrive over a valid/ready handshake. Each word is
//   shifted out LSB-first onto ccff_head, one bit for each cycle that
//   ccff_shift_en is high. The load stops after exactly CHAIN_LEN bits.
//
// Optional feature (macro FABRIC_CCFF_LOADER_READBACK_EN):
//   After the load, the chain is rotated once more, for CHAIN_LEN cycles, with
//   ccff_tail fed back into ccff_head. The parity of the bits read back is
//   compared with the parity of the bits loaded. A mismatch raises err in DONE.
//   Without the macro there is no VERIFY state and err is tied low.
//
// Ports:
//   prog_clk       programming clock, all state updates on its rising edge
//   pReset         synchronous active-low reset
//   start          begin a load (honoured in IDLE or DONE only)
//   cfg_data       configuration word, bit 0 shifted first
//   cfg_valid      cfg_data is valid
//   cfg_ready      loader accepts a word this cycle (state == LOAD)
//   ccff_head      serial data into the chain
//   ccff_shift_en  chain clock-gate enable, one chain shift per high cycle
//   ccff_tail      serial data from the end of the chain
//   busy           high in LOAD, SHIFT and VERIFY
//   done           load complete, held in DONE
//   err            readback parity mismatch (optional feature)
// -----------------------------------------------------------------------------
module fabric_ccff_loader #(
  parameter int CHAIN_LEN = 24,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_VERIFY,
    S_DONE
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [CNT_W-1:0]  bit_cnt_d;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;
  logic [WORD_W-1:0] shreg_q;
  logic [WORD_W-1:0] shreg_d;
  logic              head_q;
  logic              last_bit;
  logic              last_idx;

`ifdef FABRIC_CCFF_LOADER_READBACK_EN
  logic              load_par_q;
  logic              tail_par_q;
  logic              err_q;
`endif

  assign bit_cnt_d = bit_cnt_q + CNT_W'(1);
  assign idx_d     = idx_q + IDX_W'(1);
  assign shreg_d   = shreg_q >> 1;
  // The terminal compare stops the counter at CHAIN_LEN, so it never wraps.
  assign last_bit  = (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));
  assign last_idx  = (idx_q == IDX_W'(WORD_W - 1));

  // Main sequencer. Reset has priority and aborts any load in progress.
  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      head_q     <= 1'b0;
`ifdef FABRIC_CCFF_LOADER_READBACK_EN
      load_par_q <= 1'b0;
      tail_par_q <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q    <= S_LOAD;
            bit_cnt_q  <= '0;
`ifdef FABRIC_CCFF_LOADER_READBACK_EN
            load_par_q <= 1'b0;
            err_q      <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (cfg_valid) begin
            shreg_q <= cfg_data;
            idx_q   <= '0;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          head_q    <= shreg_q[0];
          shreg_q   <= shreg_d;
          bit_cnt_q <= bit_cnt_d;
          idx_q     <= idx_d;
`ifdef FABRIC_CCFF_LOADER_READBACK_EN
          load_par_q <= load_par_q ^ shreg_q[0];
`endif
          // The chain end wins over the word end: leftover word bits are dropped.
          if (last_bit) begin
`ifdef FABRIC_CCFF_LOADER_READBACK_EN
            state_q    <= S_VERIFY;
            bit_cnt_q  <= '0;
            tail_par_q <= 1'b0;
`else
            state_q    <= S_DONE;
`endif
          end else if (last_idx) begin
            state_q <= S_LOAD;
          end
        end
`ifdef FABRIC_CCFF_LOADER_READBACK_EN
        // The chain is rotated once so it ends holding its loaded contents,
        // and the parity of everything read back is accumulated.
        S_VERIFY: begin
          head_q     <= ccff_tail;
          bit_cnt_q  <= bit_cnt_d;
          tail_par_q <= tail_par_q ^ ccff_tail;
          if (last_bit) begin
            err_q   <= (tail_par_q ^ ccff_tail) != load_par_q;
            state_q <= S_DONE;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the registered state. ccff_head keeps its last
  // driven value whenever the chain is not shifting.
  always_comb begin
    ccff_head = head_q;
    if (state_q == S_SHIFT) begin
      ccff_head = shreg_q[0];
    end
`ifdef FABRIC_CCFF_LOADER_READBACK_EN
    else if (state_q == S_VERIFY) begin
      ccff_head = ccff_tail;
    end
`endif
  end

  assign cfg_ready = (state_q == S_LOAD);
  assign done      = (state_q == S_DONE);

`ifdef FABRIC_CCFF_LOADER_READBACK_EN
  assign ccff_shift_en = (state_q == S_SHIFT) || (state_q == S_VERIFY);
  assign busy          = (state_q == S_LOAD) || (state_q == S_SHIFT) ||
                         (state_q == S_VERIFY);
  assign err           = err_q;
`else
  assign ccff_shift_en = (state_q == S_SHIFT);
  assign busy          = (state_q == S_LOAD) || (state_q == S_SHIFT);
  // The tail is only observed by readback. Keep it referenced, with err held low.
  assign err           = ccff_tail & 1'b0;
`endif

endmodule
